ram_1port_master: RTL and testbench

- Initiator for the team's single-port RAM (enb=1 write at clock edge; enb=0 combinational read, r_data forced 0 while enb=1).
- Accepts client write and read requests over valid/ready, serializes them onto the one RAM port, and returns read data over a valid/ready response channel.
- Also provides a whole-array fill sweep used for RAM initialisation at boot.

---
 rtl/ram_1port_pkg.sv | 18 +
 rtl/ram_1port_rr_arb.sv | 46 ++++
 rtl/ram_1port_master.sv | 133 +++++++++++++
 tb/tb_ram_1port_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_1port_pkg.sv
// Shared definitions for the single-port RAM initiator: controller states,
// default geometry and the RAM enable encoding.
package ram_1port_pkg;

    localparam int DEFAULT_AW = 7;
    localparam int DEFAULT_DW = 4;

    // RAM enb encoding: 1 writes at the clock edge, 0 reads combinationally.
    localparam logic ENB_WRITE = 1'b1;
    localparam logic ENB_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ram_1port_rr_arb.sv
// Two-requester round-robin arbiter (write vs. read). A lone requester always
// wins. On a tie the pointer picks the winner, then flips so the loser wins
// the next tie. The pointer is untouched on cycles without a tie.
module ram_1port_rr_arb
    import ram_1port_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic req_wr,
    input  logic req_rd,
    output logic grant_wr,
    output logic grant_rd
);

    // ptr = 0 gives the write side priority on a tie, ptr = 1 gives the read side.
    logic ptr;
    logic tie;

    assign tie = enable && req_wr && req_rd;

    // Grant selection: one winner at most, and nothing while disabled.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (enable) begin
            if (req_wr && req_rd) begin
                grant_wr = (ptr == 1'b0);
                grant_rd = (ptr == 1'b1);
            end else begin
                grant_wr = req_wr;
                grant_rd = req_rd;
            end
        end
    end

    // Pointer register: the tie winner hands priority to the loser.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (tie) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/ram_1port_master.sv
// Initiator for the single-port RAM. Serializes client writes and reads onto
// the one RAM port, returns read data on a valid/ready response channel, and
// can sweep the whole array with a constant value for boot-time initialisation.
module ram_1port_master
    import ram_1port_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [AW-1:0] rsp_addr,
    input  logic          fill_start,
    input  logic [DW-1:0] fill_data,
    output logic          fill_busy,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] fill_cnt;
    logic [DW-1:0] fill_val;
    logic          arb_enable;
    logic          grant_wr;
    logic          grant_rd;

    // Requests are only arbitrated in IDLE, and a fill request pre-empts them.
    assign arb_enable = !rst && (state == IDLE) && !fill_start;

    ram_1port_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .enable   (arb_enable),
        .req_wr   (wr_valid),
        .req_rd   (rd_valid),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    assign fill_busy = !rst && (state == FILL);

    // Next state and RAM port drive; the port is idle (read, address 0) by default.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        ram_enb    = ENB_READ;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    state_next = FILL;
                end else if (grant_wr) begin
                    wr_ready  = 1'b1;
                    ram_enb   = ENB_WRITE;
                    ram_addr  = wr_addr;
                    ram_wdata = wr_data;
                end else if (grant_rd) begin
                    rd_ready   = 1'b1;
                    ram_addr   = rd_addr;
                    state_next = RESP;
                end
            end
            FILL: begin
                ram_enb   = ENB_WRITE;
                ram_addr  = fill_cnt;
                ram_wdata = fill_val;
                if (fill_cnt == CNT_LAST) begin
                    state_next = IDLE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            wr_ready = 1'b0;
            rd_ready = 1'b0;
            ram_enb  = ENB_READ;
        end
    end

    // State, response capture and fill sweep registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
            fill_cnt  <= '0;
            fill_val  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && fill_start) begin
                fill_val <= fill_data;
                fill_cnt <= '0;
            end
            if (rd_ready) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ram_rdata;
                rsp_addr  <= rd_addr;
            end
            if (state == FILL) begin
                fill_cnt <= (fill_cnt == CNT_LAST) ? '0 : fill_cnt + 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_1port_master.sv
// Directed bench for ram_1port_master with a behavioural single-port RAM.
module tb_ram_1port_master;

    localparam int AW = 7;
    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          fill_start;
    logic [DW-1:0] fill_data;
    logic          fill_busy;
    logic          ram_enb;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    ram_1port_master #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_addr   (rsp_addr),
        .fill_start (fill_start),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .ram_enb    (ram_enb),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write on the edge when enb=1, combinational read otherwise.
    always @(posedge clk) begin
        if (ram_enb) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ram_enb ? '0 : mem[ram_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full read transaction: grant in the request cycle, response the next.
    task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        rd_valid = 1'b1;
        rd_addr  = addr;
        #1;
        check({tag, "_rd_ready"}, {31'd0, rd_ready}, 32'd1);
        tick();
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check({tag, "_rsp"}, {21'd0, rsp_valid, rsp_addr, rsp_data}, {21'd0, 1'b1, addr, exp});
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 4'hF;
        rst = 1'b1;
        wr_valid = 1'b1; wr_addr = 7'h20; wr_data = 4'h5;
        rd_valid = 1'b1; rd_addr = 7'h21;
        rsp_ready = 1'b1;
        fill_start = 1'b0; fill_data = 4'h0;

        // Reset: outputs idle even with requests pending.
        tick();
        tick();
        check("rst_ready_enb", {29'd0, wr_ready, rd_ready, ram_enb}, 32'd0);
        check("rst_rsp", {20'd0, rsp_valid, fill_busy, rsp_addr, rsp_data}, 32'd0);

        // Tie from reset: write, read, write, read.
        rst = 1'b0;
        #1;
        check("tie1_wr", {30'd0, wr_ready, rd_ready}, 32'b10);
        check("tie1_port", {20'd0, ram_enb, ram_addr, ram_wdata}, {20'd0, 1'b1, 7'h20, 4'h5});
        tick();
        check("tie2_rd", {30'd0, wr_ready, rd_ready}, 32'b01);
        check("tie2_enb", {31'd0, ram_enb}, 32'd0);
        tick();
        check("tie2_rsp", {21'd0, rsp_valid, rsp_addr, rsp_data}, {21'd0, 1'b1, 7'h21, 4'hF});
        check("tie2_resp_ready", {30'd0, wr_ready, rd_ready}, 32'b00);
        tick();
        check("tie3_wr", {30'd0, wr_ready, rd_ready}, 32'b10);
        tick();
        check("tie4_rd", {30'd0, wr_ready, rd_ready}, 32'b01);
        tick();
        check("tie4_rsp", {31'd0, rsp_valid}, 32'd1);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        tick();
        check("idle_port", {20'd0, ram_enb, ram_addr, ram_wdata}, 32'd0);

        // Write then read of address 0x05 (lone requests leave the pointer alone).
        wr_valid = 1'b1; wr_addr = 7'h05; wr_data = 4'hA;
        #1;
        check("w5_port", {21'd0, wr_ready, ram_enb, ram_addr, ram_wdata}, {21'd0, 1'b1, 1'b1, 7'h05, 4'hA});
        tick();
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 7'h05;
        #1;
        check("r5_grant", {22'd0, rd_ready, ram_enb, ram_addr}, {22'd0, 1'b1, 1'b0, 7'h05});
        tick();
        rd_valid = 1'b0;
        #1;
        check("r5_rsp", {21'd0, rsp_valid, rsp_addr, rsp_data}, {21'd0, 1'b1, 7'h05, 4'hA});
        tick();
        check("r5_rsp_clear", {31'd0, rsp_valid}, 32'd0);

        // Pointer still favours write; write 0x10=3, then the tie goes to read 0x10.
        wr_valid = 1'b1; wr_addr = 7'h10; wr_data = 4'h3;
        rd_valid = 1'b1; rd_addr = 7'h10;
        rsp_ready = 1'b0;
        #1;
        check("tie5_wr", {30'd0, wr_ready, rd_ready}, 32'b10);
        tick();
        check("tie6_rd", {30'd0, wr_ready, rd_ready}, 32'b01);
        tick();
        rd_valid = 1'b0;
        wr_addr = 7'h11; wr_data = 4'h9;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold", {19'd0, wr_ready, rd_ready, rsp_valid, rsp_addr, rsp_data},
                  {19'd0, 1'b0, 1'b0, 1'b1, 7'h10, 4'h3});
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release", {29'd0, wr_ready, rsp_valid, rsp_data == 4'h3}, 32'b011);
        tick();
        check("bp_idle", {30'd0, wr_ready, rsp_valid}, 32'b10);
        tick();
        wr_valid = 1'b0;

        // Fill 0x7 requested together with a write; the write waits for the sweep.
        fill_start = 1'b1; fill_data = 4'h7;
        wr_valid = 1'b1; wr_addr = 7'h41; wr_data = 4'h2;
        #1;
        check("fill_req", {30'd0, wr_ready, ram_enb}, 32'd0);
        tick();
        for (int i = 0; i < (1 << AW); i++) begin
            fill_start = (i == 60);
            fill_data  = (i == 60) ? 4'h1 : 4'h7;
            #1;
            check("fill_step", {18'd0, fill_busy, ram_enb, wr_ready, ram_addr, ram_wdata},
                  {18'd0, 1'b1, 1'b1, 1'b0, i[6:0], 4'h7});
            tick();
        end
        fill_start = 1'b0;
        #1;
        check("fill_end_wr", {19'd0, fill_busy, wr_ready, ram_enb, ram_addr, ram_wdata},
              {19'd0, 1'b0, 1'b1, 1'b1, 7'h41, 4'h2});
        tick();
        wr_valid = 1'b0;
        do_read("fr00", 7'h00, 4'h7);
        do_read("fr40", 7'h40, 4'h7);
        do_read("fr7f", 7'h7F, 4'h7);
        do_read("fr41", 7'h41, 4'h2);
        do_read("fr05", 7'h05, 4'h7);

        // Fill 0xC, reset when the counter reaches 50.
        fill_start = 1'b1; fill_data = 4'hC;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        #1;
        check("mid_addr", {25'd0, ram_addr}, 32'd50);
        rst = 1'b1;
        #1;
        check("mid_rst_enb", {31'd0, ram_enb}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_idle", {30'd0, fill_busy, ram_enb}, 32'd0);
        do_read("mr00", 7'h00, 4'hC);
        do_read("mr31", 7'h31, 4'hC);
        do_read("mr32", 7'h32, 4'h7);
        do_read("mr33", 7'h33, 4'h7);
        do_read("mr41", 7'h41, 4'h2);
        do_read("mr7f", 7'h7F, 4'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
